// File: rtl/pc_stack_if.sv
// Request/response bundle between a sequencer and the program-counter
// stack: jump, branch, call and return requests in, PC and stack status out.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             rel;
  logic             call;
  logic             ret;
  logic             stall;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic [1:0]       err;

  modport master (
    output in, load, inc, rel, call, ret, stall,
    input  out, depth, full, empty, err
  );

  modport slave (
    input  in, load, inc, rel, call, ret, stall,
    output out, depth, full, empty, err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a return-address stack (load > call > ret > rel > inc).
// Define PC_STACK_ERR_EN to add sticky overflow/underflow flags on err.
module pc_stack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         reset,
  pc_stack_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  typedef enum logic [2:0] {
    OP_HOLD, OP_LOAD, OP_CALL, OP_RET, OP_REL, OP_INC
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PW-1:0]    top_idx;
  logic             full, empty;
  logic             push;
  logic             ovf, udf;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign top_idx = PW'(depth_q - DW'(1));

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    op      = OP_HOLD;
    out_d   = out_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf     = 1'b0;
    udf     = 1'b0;

    if      (bus.load) op = OP_LOAD;
    else if (bus.call) op = OP_CALL;
    else if (bus.ret)  op = OP_RET;
    else if (bus.rel)  op = OP_REL;
    else if (bus.inc)  op = OP_INC;

    if (!bus.stall) begin
      unique case (op)
        OP_LOAD: out_d = bus.in;
        OP_CALL: begin
          if (!full) begin
            push    = 1'b1;
            depth_d = depth_q + DW'(1);
            out_d   = bus.in;
          end else begin
            ovf = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            out_d   = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end else begin
            udf = 1'b1;
          end
        end
        // Two's-complement offset: plain modular addition gives signed behaviour.
        OP_REL:  out_d = out_q + bus.in;
        OP_INC:  out_d = out_q + WIDTH'(1);
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= RESET_VEC;
      depth_q <= '0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; depth_q == 0 already marks
  // every entry invalid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) stack_q[depth_q[PW-1:0]] <= out_q + WIDTH'(1);
  end

`ifdef PC_STACK_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 2'b00;
    else        err_q <= err_q | {udf, ovf};
  end

  assign bus.err = err_q;
`else
  logic unused_flags;
  assign unused_flags = ovf ^ udf;
  assign bus.err      = 2'b00;
`endif

  assign bus.out   = out_q;
  assign bus.depth = depth_q;
  assign bus.full  = full;
  assign bus.empty = empty;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (WIDTH=16, DEPTH=4): directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_pc_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Reference model: PC value, return stack as a queue, sticky error bits.
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stk[$];
  logic [1:0]       m_err;

  pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_pc  = 16'h0000;
    m_stk = {};
    m_err = 2'b00;
  endtask

  task automatic m_step(input logic [WIDTH-1:0] i, input bit ld, input bit c,
                        input bit r, input bit rl, input bit ic, input bit st);
    if (st) return;
    if (ld) begin
      m_pc = i;
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = i;
      end else if (ERR_EN) begin
        m_err[0] = 1'b1;
      end
    end else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else if (ERR_EN)      m_err[1] = 1'b1;
    end else if (rl) begin
      m_pc = m_pc + i;
    end else if (ic) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Drive one request at a negedge, let it take effect, return at next negedge.
  task automatic cycle(input logic [WIDTH-1:0] i, input bit ld, input bit c,
                       input bit r, input bit rl, input bit ic, input bit st);
    bus.in    = i;
    bus.load  = ld;
    bus.call  = c;
    bus.ret   = r;
    bus.rel   = rl;
    bus.inc   = ic;
    bus.stall = st;
    @(posedge clk);
    m_step(i, ld, c, r, rl, ic, st);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in = '0; bus.load = 0; bus.call = 0; bus.ret = 0;
    bus.rel = 0; bus.inc = 0; bus.stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out !== 16'h0000 || bus.depth !== 3'd0 || bus.err !== 2'b00 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: out=%h depth=%0d err=%b empty=%b, want out=0000 depth=0 err=00 empty=1",
               bus.out, bus.depth, bus.err, bus.empty);
    end
    reset = 1'b1;
    m_reset();
    for (int k = 1; k <= 3; k++) begin
      cycle(16'h0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (bus.out !== WIDTH'(k)) begin
        failures++;
        $display("FAIL inc_seq: out=%h, want %h", bus.out, WIDTH'(k));
      end
    end
    // Assert reset between edges with a request pending; out must clear at once.
    bus.inc = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.out !== 16'h0000 || bus.depth !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: out=%h depth=%0d, want out=0000 depth=0", bus.out, bus.depth);
    end
    @(negedge clk);
    checks++;
    if (bus.out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold: out=%h, want 0000", bus.out);
    end
    reset = 1'b1;
    m_reset();
    cycle(16'h0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.out !== 16'h0001) begin
      failures++;
      $display("FAIL first_after_reset: out=%h, want 0001", bus.out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(16'hFFFF, 1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== 16'hFFFF) begin
      failures++;
      $display("FAIL load_ffff: out=%h, want ffff", bus.out);
    end
    cycle(16'h0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (bus.out !== 16'h0000) begin
      failures++;
      $display("FAIL inc_wrap: out=%h, want 0000", bus.out);
    end
    cycle(16'hFFFE, 0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.out !== 16'hFFFE) begin
      failures++;
      $display("FAIL rel_neg: out=%h, want fffe", bus.out);
    end
    cycle(16'h0003, 0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.out !== 16'h0001) begin
      failures++;
      $display("FAIL rel_pos: out=%h, want 0001", bus.out);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    cycle(16'h0010, 1, 0, 0, 0, 0, 0);
    cycle(16'h0100, 0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.out !== 16'h0100 || bus.depth !== 3'd1 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL call: out=%h depth=%0d empty=%b, want out=0100 depth=1 empty=0",
               bus.out, bus.depth, bus.empty);
    end
    cycle(16'h0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (bus.out !== 16'h0011 || bus.depth !== 3'd0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL ret: out=%h depth=%0d empty=%b, want out=0011 depth=0 empty=1",
               bus.out, bus.depth, bus.empty);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [WIDTH-1:0] ret_pc [4];
    logic [1:0]       want_err;
    ret_pc = '{16'h1201, 16'h1101, 16'h1001, 16'h0001};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(16'h1000 + WIDTH'(k) * 16'h0100, 0, 1, 0, 0, 0, 0);
      checks++;
      if (bus.depth !== 3'(k + 1) || bus.full !== (k == 3)) begin
        failures++;
        $display("FAIL call_fill: depth=%0d full=%b, want depth=%0d full=%b",
                 bus.depth, bus.full, k + 1, (k == 3));
      end
    end
    cycle(16'h2000, 0, 1, 0, 0, 0, 0);
    want_err = ERR_EN ? 2'b01 : 2'b00;
    checks++;
    if (bus.out !== 16'h1300 || bus.depth !== 3'd4 || bus.err !== want_err) begin
      failures++;
      $display("FAIL overflow: out=%h depth=%0d err=%b, want out=1300 depth=4 err=%b",
               bus.out, bus.depth, bus.err, want_err);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(16'h0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (bus.out !== ret_pc[k] || bus.depth !== 3'(3 - k)) begin
        failures++;
        $display("FAIL ret_lifo: out=%h depth=%0d, want out=%h depth=%0d",
                 bus.out, bus.depth, ret_pc[k], 3 - k);
      end
    end
    cycle(16'h0, 0, 0, 1, 0, 0, 0);
    want_err = ERR_EN ? 2'b11 : 2'b00;
    checks++;
    if (bus.out !== 16'h0001 || bus.depth !== 3'd0 || bus.err !== want_err) begin
      failures++;
      $display("FAIL underflow: out=%h depth=%0d err=%b, want out=0001 depth=0 err=%b",
               bus.out, bus.depth, bus.err, want_err);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cycle(16'h0020, 1, 0, 0, 0, 0, 0);
    cycle(16'h0200, 0, 1, 0, 0, 0, 0);
    cycle(16'h0040, 1, 1, 0, 0, 1, 0);
    checks++;
    if (bus.out !== 16'h0040 || bus.depth !== 3'd1) begin
      failures++;
      $display("FAIL prio_load: out=%h depth=%0d, want out=0040 depth=1", bus.out, bus.depth);
    end
    cycle(16'h0077, 1, 1, 1, 1, 1, 1);
    checks++;
    if (bus.out !== 16'h0040 || bus.depth !== 3'd1) begin
      failures++;
      $display("FAIL stall: out=%h depth=%0d, want out=0040 depth=1", bus.out, bus.depth);
    end
    cycle(16'h0300, 0, 1, 1, 1, 1, 0);
    checks++;
    if (bus.out !== 16'h0300 || bus.depth !== 3'd2) begin
      failures++;
      $display("FAIL prio_call: out=%h depth=%0d, want out=0300 depth=2", bus.out, bus.depth);
    end
    cycle(16'h0500, 0, 0, 1, 1, 1, 0);
    checks++;
    if (bus.out !== 16'h0041 || bus.depth !== 3'd1) begin
      failures++;
      $display("FAIL prio_ret: out=%h depth=%0d, want out=0041 depth=1", bus.out, bus.depth);
    end
    cycle(16'h0010, 0, 0, 0, 1, 1, 0);
    checks++;
    if (bus.out !== 16'h0051) begin
      failures++;
      $display("FAIL prio_rel: out=%h, want 0051", bus.out);
    end
    cycle(16'h0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.out !== 16'h0051) begin
      failures++;
      $display("FAIL idle_hold: out=%h, want 0051", bus.out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      cycle(WIDTH'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0);
      checks++;
      if (bus.out !== m_pc || bus.depth !== 3'(m_stk.size()) || bus.err !== m_err ||
          bus.full !== (m_stk.size() == DEPTH) || bus.empty !== (m_stk.size() == 0)) begin
        failures++;
        $display("FAIL random[%0d]: out=%h depth=%0d err=%b full=%b empty=%b, want out=%h depth=%0d err=%b",
                 n, bus.out, bus.depth, bus.err, bus.full, bus.empty, m_pc, m_stk.size(), m_err);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle_inputs();
    m_reset();
    test_reset();
    test_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, program-counter and data width in bits (>= 4).
REQ-002 Parameter DEPTH, default 8, return-address stack entries (power of two, >= 2).
REQ-003 Parameter RESET_VEC, default 0, value loaded into out on reset.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in  input  WIDTH  absolute target (load/call) or two's-complement offset (rel).
REQ-007 load  input  1  absolute jump request.
REQ-008 inc  input  1  sequential increment request.
REQ-009 rel  input  1  relative branch request.
REQ-010 call  input  1  subroutine call request.
REQ-011 ret  input  1  subroutine return request.
REQ-012 stall  input  1  freeze all state this cycle.
REQ-013 out  output  WIDTH  current program counter, registered.
REQ-014 depth  output  $clog2(DEPTH)+1  number of valid stack entries.
REQ-015 full  output  1  depth == DEPTH, combinational from depth.
REQ-016 empty  output  1  depth == 0, combinational from depth.
REQ-017 err  output  2  sticky error flags: bit0 overflow, bit1 underflow.

Function
REQ-018 All requests sampled on rising clk; effect visible on out one cycle later (latency 1).
REQ-019 stall=1 SHALL hold out, stack, depth and err regardless of other inputs.
REQ-020 Priority when several requests are high: load > call > ret > rel > inc; lower-priority requests ignored that cycle.
REQ-021 No request asserted SHALL hold out unchanged.
REQ-022 inc: out <= out + 1, modulo 2^WIDTH (all-ones wraps to 0).
REQ-023 rel: out <= out + in, in treated as signed, result modulo 2^WIDTH.
REQ-024 load: out <= in; stack and depth unchanged.
REQ-025 call with full=0: push out + 1 (modulo 2^WIDTH) onto stack, depth + 1, out <= in, all in the same edge.
REQ-026 call with full=1: no push, out and depth unchanged, overflow condition raised.
REQ-027 ret with empty=0: out <= top entry, depth - 1.
REQ-028 ret with empty=1: out and depth unchanged, underflow condition raised.
REQ-029 Stack is LIFO; entries beyond depth are don't-care and never observable on out.
REQ-030 depth SHALL never exceed DEPTH or go below 0.

Reset
REQ-031 reset low SHALL immediately, without clk, force out = RESET_VEC, depth = 0, err = 0.
REQ-032 Stack storage contents need not be cleared; depth = 0 makes them invalid.
REQ-033 reset asserted mid-operation SHALL discard any pending request; first request honoured is on the first rising edge after reset is released.

Configuration
REQ-034 Macro PC_STACK_ERR_EN defined: err bit0 set on REQ-026 event, bit1 set on REQ-028 event, both stay set until reset.
REQ-035 Macro PC_STACK_ERR_EN undefined: err tied to 2'b00, no flag registers; all other behaviour identical.

Verification (WIDTH=16, DEPTH=4, RESET_VEC=0, PC_STACK_ERR_EN defined unless noted)
REQ-036 Release reset, inc=1 for 3 cycles -> out 0,1,2,3; assert reset between edges -> out=0 immediately.
REQ-037 load in=16'hFFFF, then inc -> out=16'hFFFF then 16'h0000; then rel in=16'hFFFE (-2) -> out=16'hFFFE.
REQ-038 out=16'h0010, call in=16'h0100 -> out=16'h0100, depth=1; ret -> out=16'h0011, depth=0, empty=1.
REQ-039 5 calls from empty -> depth=4, full=1 after 4th; 5th call leaves out and depth unchanged, err=2'b01; 5 rets -> last ret holds out, err=2'b11.
REQ-040 load=1, call=1, inc=1 together, in=16'h0040 -> out=16'h0040, depth unchanged; same with stall=1 -> nothing changes.
REQ-041 PC_STACK_ERR_EN undefined, ret on empty -> out unchanged, err stays 2'b00.
